// File: rtl/pkt_filter_pkg.sv
// Shared definitions for the packet framing blocks: token encodings, tracker
// states and packet length width.
package pkt_filter_pkg;

  localparam int PKT_LEN_WIDTH = 11;

  localparam logic [2:0] TOK_STP = 3'd0;
  localparam logic [2:0] TOK_SDP = 3'd1;
  localparam logic [2:0] TOK_IDL = 3'd2;
  localparam logic [2:0] TOK_INV = 3'd3;
  localparam logic [2:0] TOK_EDS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TLP  = 3'd1,
    ST_DLLP = 3'd2,
    ST_EOS  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
    return (en && value != 16'hFFFF) ? value + 16'd1 : value;
  endfunction

endpackage

// File: rtl/packet_boundary_tracker_if.sv
// DW stream in, framed DW qualifiers out. The stats counters exist only when
// PKT_TRACKER_STATS_EN is defined.
interface packet_boundary_tracker_if #(
  parameter int FRAME_DEPTH  = 4,
  parameter int SYMBOL_WIDTH = 8
);
  localparam int DATA_W = FRAME_DEPTH * SYMBOL_WIDTH;

  logic              i_valid;
  logic [0:DATA_W-1] i_data;
  logic [2:0]        i_token_type;
  logic              i_block_start;

  logic [0:DATA_W-1] o_data;
  logic              o_tlp_valid;
  logic              o_tlp_sop;
  logic              o_tlp_eop;
  logic              o_dllp_valid;
  logic              o_dllp_sop;
  logic              o_dllp_eop;
  logic              o_eds;
  logic              o_framing_err;
`ifdef PKT_TRACKER_STATS_EN
  logic [15:0]       o_tlp_cnt;
  logic [15:0]       o_dllp_cnt;
  logic [15:0]       o_err_cnt;
`endif

  modport master (
    output i_valid, i_data, i_token_type, i_block_start,
    input  o_data, o_tlp_valid, o_tlp_sop, o_tlp_eop,
    input  o_dllp_valid, o_dllp_sop, o_dllp_eop, o_eds, o_framing_err
`ifdef PKT_TRACKER_STATS_EN
    , input o_tlp_cnt, o_dllp_cnt, o_err_cnt
`endif
  );

  modport slave (
    input  i_valid, i_data, i_token_type, i_block_start,
    output o_data, o_tlp_valid, o_tlp_sop, o_tlp_eop,
    output o_dllp_valid, o_dllp_sop, o_dllp_eop, o_eds, o_framing_err
`ifdef PKT_TRACKER_STATS_EN
    , output o_tlp_cnt, o_dllp_cnt, o_err_cnt
`endif
  );

endinterface

// File: rtl/packet_boundary_tracker.sv
// Tracks TLP/DLLP boundaries in a framed DW stream. Optional packet/error
// counters are built in when PKT_TRACKER_STATS_EN is defined.
//
//   state   | meaning
//   IDLE    | between packets, classifying each valid DW by token type
//   TLP     | inside a TLP, rem DWs still to come
//   DLLP    | after an SDP, waiting for the second DLLP DW
//   EOS     | after EDS, waiting for the next block start
//   ERR     | after a framing error, waiting for the next block start
module packet_boundary_tracker
  import pkt_filter_pkg::*;
#(
  parameter int FRAME_DEPTH  = 4,
  parameter int SYMBOL_WIDTH = 8
) (
  input logic i_clk,
  input logic i_rst,
  packet_boundary_tracker_if.slave bus
);

  localparam int DATA_W = FRAME_DEPTH * SYMBOL_WIDTH;

  state_t                   state;
  logic [PKT_LEN_WIDTH-1:0] rem;
  logic [PKT_LEN_WIDTH-1:0] len;
  logic [0:DATA_W-1]        data_q;
  logic                     take_token;

  assign len = {bus.i_data[9:15], bus.i_data[0:3]};
  // A block-start DW that ends EOS/ERR is itself classified as if in IDLE.
  assign take_token = (state == ST_IDLE) ||
                      (((state == ST_EOS) || (state == ST_ERR)) && bus.i_block_start);
  assign bus.o_data = data_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= ST_IDLE;
      rem               <= '0;
      data_q            <= '0;
      bus.o_tlp_valid   <= 1'b0;
      bus.o_tlp_sop     <= 1'b0;
      bus.o_tlp_eop     <= 1'b0;
      bus.o_dllp_valid  <= 1'b0;
      bus.o_dllp_sop    <= 1'b0;
      bus.o_dllp_eop    <= 1'b0;
      bus.o_eds         <= 1'b0;
      bus.o_framing_err <= 1'b0;
    end else begin
      data_q            <= bus.i_data;
      bus.o_tlp_valid   <= 1'b0;
      bus.o_tlp_sop     <= 1'b0;
      bus.o_tlp_eop     <= 1'b0;
      bus.o_dllp_valid  <= 1'b0;
      bus.o_dllp_sop    <= 1'b0;
      bus.o_dllp_eop    <= 1'b0;
      bus.o_eds         <= 1'b0;
      bus.o_framing_err <= 1'b0;
      if (bus.i_valid) begin
        if (take_token) begin
          case (bus.i_token_type)
            TOK_STP: begin
              if (len == '0) begin
                bus.o_framing_err <= 1'b1;
                state             <= ST_ERR;
              end else begin
                bus.o_tlp_valid <= 1'b1;
                bus.o_tlp_sop   <= 1'b1;
                rem             <= len - 1'b1;
                if (len == 11'd1) begin
                  bus.o_tlp_eop <= 1'b1;
                  state         <= ST_IDLE;
                end else begin
                  state <= ST_TLP;
                end
              end
            end
            TOK_SDP: begin
              bus.o_dllp_valid <= 1'b1;
              bus.o_dllp_sop   <= 1'b1;
              state            <= ST_DLLP;
            end
            TOK_IDL: state <= ST_IDLE;
            TOK_EDS: begin
              bus.o_eds <= 1'b1;
              state     <= ST_EOS;
            end
            default: begin
              bus.o_framing_err <= 1'b1;
              state             <= ST_ERR;
            end
          endcase
        end else if (state == ST_TLP) begin
          bus.o_tlp_valid <= 1'b1;
          rem             <= rem - 1'b1;
          if (rem == 11'd1) begin
            bus.o_tlp_eop <= 1'b1;
            state         <= ST_IDLE;
          end
        end else if (state == ST_DLLP) begin
          bus.o_dllp_valid <= 1'b1;
          bus.o_dllp_eop   <= 1'b1;
          state            <= ST_IDLE;
        end
      end
    end
  end

`ifdef PKT_TRACKER_STATS_EN
  // Counters follow the registered event pulses, so they lag them by a cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_tlp_cnt  <= '0;
      bus.o_dllp_cnt <= '0;
      bus.o_err_cnt  <= '0;
    end else begin
      bus.o_tlp_cnt  <= sat_inc(bus.o_tlp_cnt, bus.o_tlp_eop);
      bus.o_dllp_cnt <= sat_inc(bus.o_dllp_cnt, bus.o_dllp_eop);
      bus.o_err_cnt  <= sat_inc(bus.o_err_cnt, bus.o_framing_err);
    end
  end
`endif

endmodule

// File: doc/packet_boundary_tracker.md
PACKET_BOUNDARY_TRACKER -- requirements
Module: packet_boundary_tracker

Interface
REQ-001 SHALL have parameter FRAME_DEPTH, default 4, giving symbols per cycle (one DW).
REQ-002 SHALL have parameter SYMBOL_WIDTH, default 8, giving bits per symbol.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1, meaning i_data and i_token_type are valid this cycle.
REQ-006 SHALL have port i_data, input, [0:FRAME_DEPTH*SYMBOL_WIDTH-1], one DW with symbol 0 at bits 0..7.
REQ-007 SHALL have port i_token_type, input, 3, the token classification of i_data: 0 STP, 1 SDP, 2 IDL, 3 invalid, 4 EDS.
REQ-008 SHALL have port i_block_start, input, 1, pulsed on the first DW of a new data block.
REQ-009 SHALL have port o_data, output, same width as i_data, the registered copy of i_data.
REQ-010 SHALL have ports o_tlp_valid, o_tlp_sop and o_tlp_eop, outputs, 1 each, the TLP DW qualifiers.
REQ-011 SHALL have ports o_dllp_valid, o_dllp_sop and o_dllp_eop, outputs, 1 each, the DLLP DW qualifiers.
REQ-012 SHALL have ports o_eds and o_framing_err, outputs, 1 each, single-cycle event pulses.

Function
REQ-013 SHALL implement the states IDLE, TLP, DLLP, EOS and ERR.
REQ-014 SHALL register all outputs, giving exactly one cycle of latency from i_valid to the output qualifiers.
REQ-015 SHALL, in IDLE with i_valid high, act on i_token_type as follows:
- STP: assert tlp_valid and tlp_sop, load rem = len-1, go to TLP.
- SDP: assert dllp_valid and dllp_sop, go to DLLP.
- IDL: stay in IDLE, no output.
- EDS: pulse o_eds, go to EOS.
- invalid: pulse o_framing_err, go to ERR.
REQ-016 SHALL extract the 11-bit length in DW as len = {i_data[9:15], i_data[0:3]}, i.e. symbol-1 bits 6:0 then symbol-0 bits 7:4 in symbol bit order.
REQ-017 SHALL, in TLP with i_valid high, assert tlp_valid and decrement rem, ignoring i_token_type.
REQ-018 SHALL, in TLP, assert tlp_eop and return to IDLE when rem == 1.
REQ-019 SHALL, in DLLP with i_valid high, assert dllp_valid and dllp_eop and return to IDLE, so a DLLP is always 2 DW.
REQ-020 SHALL, in EOS and ERR, hold all outputs low, ignore i_data and stay until i_valid && i_block_start, then go to IDLE.
REQ-021 SHALL process the i_block_start DW itself as IDLE input in that same cycle.
REQ-022 SHALL ignore i_block_start in IDLE, TLP and DLLP, so packets may span blocks.
REQ-023 SHALL, when i_valid is low, hold state and counters and drive all valid, sop, eop and pulse outputs low.
REQ-024 SHALL, for an STP with len == 1 (a checker escape), assert sop and eop together and remain in IDLE.
REQ-025 SHALL, for an STP with len == 0, pulse o_framing_err and go to ERR.
REQ-026 SHALL, at the maximum len of 2047, handle the TLP correctly with an 11-bit rem counter that never wraps.

Reset
REQ-027 SHALL, when i_rst is high on a clock edge, set state to IDLE, rem to 0, o_data to 0 and all 1-bit outputs to 0.
REQ-028 SHALL, on reset mid-TLP or mid-DLLP, abandon the packet without asserting eop.
REQ-029 SHALL give reset priority over i_valid.

Configuration
REQ-030 SHALL, with PKT_TRACKER_STATS_EN defined, add the outputs o_tlp_cnt, o_dllp_cnt and o_err_cnt, 16 bits each.
REQ-031 SHALL increment these counters on tlp_eop, dllp_eop and framing_err respectively, saturating at 16'hFFFF and reset to 0.
REQ-032 SHALL, without PKT_TRACKER_STATS_EN, have neither these ports nor any counter logic, with behaviour otherwise identical.

Structure
REQ-033 SHALL take the token-type encodings, the state enum and PKT_LEN_WIDTH = 11 from a shared package pkt_filter_pkg, which the frame checker also uses.
REQ-034 SHALL be a single module with no sub-module; the stats counters are inline generate logic.

Verification
REQ-035 SHALL cover: STP with len = 5, then 4 DW -> 5 tlp_valid cycles, sop on DW0, eop on DW4, then IDLE.
REQ-036 SHALL cover: SDP followed by 1 DW -> dllp_valid for 2 cycles, sop on the first, eop on the second.
REQ-037 SHALL cover: STP with len = 8 and i_valid low for 3 cycles mid-packet -> 8 tlp_valid cycles total, eop on the 8th valid DW.
REQ-038 SHALL cover: invalid token, then 2 DW, then i_block_start with IDL -> one framing_err pulse, no valids, IDLE afterwards.
REQ-039 SHALL cover: EDS, then an i_block_start DW carrying STP len = 5 -> o_eds pulse, and tlp_sop on the block-start DW.
REQ-040 SHALL cover: i_rst at DW3 of a len = 10 TLP -> all outputs 0 next cycle, no eop, and the next STP accepted.
